// File: rtl/player_input_ctrl_if.sv
// Button vector bundle between board buttons, one player's input
// controller and the game core.
interface player_input_ctrl_if;
  logic [6:0] btn_raw;
  logic [6:0] inputs_out;
  logic [6:0] press_evt;
  logic       attack_busy;

  modport master (
    input  btn_raw,
    output inputs_out,
    output press_evt,
    output attack_busy
  );

  modport slave (
    output btn_raw,
    input  inputs_out,
    input  press_evt,
    input  attack_busy
  );
endinterface

// File: rtl/player_input_ctrl.sv
// Per-player button sync/debounce plus attack strike FSM.
// Optional SOCD cleaning: define PLAYER_INPUT_SOCD_CLEAN_EN.
module player_input_ctrl #(
  parameter int unsigned CNT_W                  = 24,
  parameter int unsigned DEBOUNCE_CYCLES        = 1_000_000,
  parameter int unsigned ATTACK_PULSE_CYCLES    = 2_000_000,
  parameter int unsigned ATTACK_COOLDOWN_CYCLES = 5_000_000
) (
  input  logic                clk,
  input  logic                reset,
  player_input_ctrl_if.master io
);

  localparam logic [CNT_W-1:0] DEB_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_MAX =
    CNT_W'(ATTACK_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_MAX =
    CNT_W'(ATTACK_COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    STRIKE,
    COOLDOWN
  } state_e;

  logic [6:0]       meta_q;
  logic [6:0]       sync_q;
  logic [6:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [7];
  logic [CNT_W-1:0] cnt_d [7];
  logic [6:0]       lvl_q;
  logic [6:0]       prev_q;
  logic [6:0]       rise;
  logic [6:0]       level_d, level_q;
  logic [6:0]       evt_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] acnt_q, acnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= io.btn_raw;
      sync_q <= meta_q;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive
  // disagreements; any agreement in between restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 7; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_MAX) begin
        stable_d[i] = sync_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stable_q <= '0;
      for (int i = 0; i < 7; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < 7; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rise = lvl_q & ~prev_q;

  always_comb begin
    level_d = lvl_q;
`ifdef PLAYER_INPUT_SOCD_CLEAN_EN
    if (lvl_q[1] && lvl_q[2]) begin
      level_d[2:1] = 2'b00;
    end
    if (lvl_q[3] && lvl_q[4]) begin
      level_d[4:3] = 2'b00;
    end
`endif
  end

  // lvl_q is an alignment stage so that level bits, press events
  // and the strike start all change on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lvl_q   <= '0;
      prev_q  <= '0;
      level_q <= '0;
      evt_q   <= '0;
    end else begin
      lvl_q   <= stable_q;
      prev_q  <= lvl_q;
      level_q <= level_d;
      evt_q   <= rise;
    end
  end

  always_comb begin
    state_d = state_q;
    acnt_d  = acnt_q;
    unique case (state_q)
      IDLE: begin
        if (rise[5] && !lvl_q[6]) begin
          state_d = STRIKE;
          acnt_d  = PULSE_MAX;
        end
      end
      STRIKE: begin
        if (acnt_q == '0) begin
          state_d = COOLDOWN;
          acnt_d  = COOL_MAX;
        end else begin
          acnt_d = acnt_q - ONE;
        end
      end
      COOLDOWN: begin
        if (acnt_q == '0) begin
          state_d = IDLE;
        end else begin
          acnt_d = acnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        acnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      acnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acnt_q  <= acnt_d;
    end
  end

  assign io.inputs_out = {
    level_q[6],
    state_q == STRIKE,
    level_q[4:0]
  };
  assign io.press_evt   = evt_q;
  assign io.attack_busy = state_q != IDLE;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Scoreboard bench for player_input_ctrl: stimulus queues expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_player_input_ctrl;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  player_input_ctrl_if bus ();

  player_input_ctrl #(
    .CNT_W                 (24),
    .DEBOUNCE_CYCLES       (4),
    .ATTACK_PULSE_CYCLES   (3),
    .ATTACK_COOLDOWN_CYCLES(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  typedef struct {
    string      tag;
    int         t;
    logic [6:0] out;
    logic [6:0] evt;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  exp_t e;

`ifdef PLAYER_INPUT_SOCD_CLEAN_EN
  localparam logic [6:0] LR = 7'h00;
`else
  localparam logic [6:0] LR = 7'h06;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_rng(
    input string      tag,
    input int         t0,
    input int         t1,
    input logic [6:0] out,
    input logic [6:0] evt,
    input logic       busy
  );
    exp_t x;
    for (int t = t0; t <= t1; t++) begin
      x.tag  = tag;
      x.t    = t;
      x.out  = out;
      x.evt  = evt;
      x.busy = busy;
      sb.push_back(x);
    end
  endtask

  // Inputs set here are sampled by posedge number t.
  task automatic at(input int t);
    while (cyc < t - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].t <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.t != cyc ||
          bus.inputs_out !== e.out ||
          bus.press_evt !== e.evt ||
          bus.attack_busy !== e.busy) begin
        errors++;
        $display("FAIL %s t=%0d/%0d out=%h exp=%h evt=%h exp=%h busy=%b exp=%b",
                 e.tag, cyc, e.t, bus.inputs_out, e.out,
                 bus.press_evt, e.evt, bus.attack_busy, e.busy);
      end
    end
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;

    expect_rng("reset",    1,  10, 7'h00, 7'h00, 1'b0);
    expect_rng("rel_rise", 11, 11, 7'h5F, 7'h7F, 1'b0);
    expect_rng("rel_hold", 12, 19, 7'h5F, 7'h00, 1'b0);
    expect_rng("rel_fall", 20, 29, 7'h00, 7'h00, 1'b0);
    reset       = 1'b0;
    bus.btn_raw = 7'h7F;
    at(4);  reset = 1'b1;
    at(13); bus.btn_raw = 7'h00;

    expect_rng("left_wait", 30, 36, 7'h00, 7'h00, 1'b0);
    expect_rng("left_rise", 37, 37, 7'h02, 7'h02, 1'b0);
    expect_rng("bounce",    38, 58, 7'h02, 7'h00, 1'b0);
    expect_rng("left_fall", 59, 61, 7'h00, 7'h00, 1'b0);
    at(30); bus.btn_raw = 7'h02;
    at(40); bus.btn_raw = 7'h06;
    at(43); bus.btn_raw = 7'h02;
    at(52); bus.btn_raw = 7'h00;

    expect_rng("atk_wait",  62, 68, 7'h00, 7'h00, 1'b0);
    expect_rng("atk_start", 69, 69, 7'h20, 7'h20, 1'b1);
    expect_rng("atk_pulse", 70, 71, 7'h20, 7'h00, 1'b1);
    expect_rng("atk_cool",  72, 76, 7'h00, 7'h00, 1'b1);
    expect_rng("atk_held",  77, 106, 7'h00, 7'h00, 1'b0);
    at(62); bus.btn_raw = 7'h20;
    at(92); bus.btn_raw = 7'h00;

    expect_rng("tap_start", 107, 107, 7'h20, 7'h20, 1'b1);
    expect_rng("tap_pulse", 108, 109, 7'h20, 7'h00, 1'b1);
    expect_rng("tap_cool",  110, 114, 7'h00, 7'h00, 1'b1);
    expect_rng("tap_drop",  115, 115, 7'h00, 7'h20, 1'b0);
    expect_rng("tap_idle",  116, 131, 7'h00, 7'h00, 1'b0);
    at(100); bus.btn_raw = 7'h20;
    at(104); bus.btn_raw = 7'h00;
    at(108); bus.btn_raw = 7'h20;
    at(112); bus.btn_raw = 7'h00;

    expect_rng("re_start", 132, 132, 7'h20, 7'h20, 1'b1);
    expect_rng("re_pulse", 133, 134, 7'h20, 7'h00, 1'b1);
    expect_rng("re_cool",  135, 139, 7'h00, 7'h00, 1'b1);
    expect_rng("re_idle",  140, 166, 7'h00, 7'h00, 1'b0);
    at(125); bus.btn_raw = 7'h20;
    at(145); bus.btn_raw = 7'h00;

    expect_rng("lr_rise",  167, 167, LR, 7'h06, 1'b0);
    expect_rng("lr_hold",  168, 176, LR, 7'h00, 1'b0);
    expect_rng("sh_rise",  177, 177, LR | 7'h40, 7'h40, 1'b0);
    expect_rng("sh_hold",  178, 186, LR | 7'h40, 7'h00, 1'b0);
    expect_rng("sh_block", 187, 187, LR | 7'h40, 7'h20, 1'b0);
    expect_rng("sh_nostr", 188, 201, LR | 7'h40, 7'h00, 1'b0);
    expect_rng("sh_fall",  202, 216, 7'h00, 7'h00, 1'b0);
    at(160); bus.btn_raw = 7'h06;
    at(170); bus.btn_raw = 7'h46;
    at(180); bus.btn_raw = 7'h66;
    at(195); bus.btn_raw = 7'h00;

    expect_rng("rs_start", 217, 217, 7'h20, 7'h20, 1'b1);
    expect_rng("rs_pulse", 218, 218, 7'h20, 7'h00, 1'b1);
    expect_rng("rs_abort", 219, 227, 7'h00, 7'h00, 1'b0);
    expect_rng("rs_held",  228, 228, 7'h20, 7'h20, 1'b1);
    expect_rng("rs_pulse2", 229, 230, 7'h20, 7'h00, 1'b1);
    expect_rng("rs_cool",  231, 235, 7'h00, 7'h00, 1'b1);
    expect_rng("rs_idle",  236, 250, 7'h00, 7'h00, 1'b0);
    at(210); bus.btn_raw = 7'h20;
    at(219); reset = 1'b0;
    at(221); reset = 1'b1;
    at(240); bus.btn_raw = 7'h00;
    at(252);

    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
